poly_voice_mixer: RTL and testbench
===================================

// Module: poly_voice_mixer
// PURPOSE
//   Parametrised polyphonic tone source for the step-sequencer audio path: NUM_VOICES NCOs, each with a
//   selectable waveform and a per-voice linear attack/release envelope, mixed by a time-multiplexed
//   accumulator and normalised by the number of sounding voices. Sits between the sequencer note
//   outputs (Gate/PhaseInc) and the audio codec sample interface; runs once per SampleTick.
// PARAMETERS
//   NUM_VOICES   12  number of voices (>=2)
//   PHASE_W      32  NCO phase accumulator width (>=AMP_W+1)
//   AMP_W        16  signed waveform and output sample width
//   ENV_W         8  unsigned envelope level width; full scale = 2^ENV_W-1
//   ATTACK_STEP   1  envelope increment per SampleTick in ATTACK
//   RELEASE_STEP  1  envelope decrement per SampleTick in RELEASE
// PORTS
//   Clock       in   1                   system clock, all state on rising edge
//   Reset       in   1                   synchronous, active-high reset
//   SampleTick  in   1                   one-cycle strobe: advance all voices and start one mix
//   PhaseInc    in   NUM_VOICES*PHASE_W  voice v increment = PhaseInc[v*PHASE_W +: PHASE_W]
//   Gate        in   NUM_VOICES          note on (1) / off (0) per voice
//   Wave        in   2                   00 saw, 01 square, 10 triangle, 11 silent
//   Out         out  AMP_W (signed)      mixed, normalised sample
//   OutValid    out  1                   one-cycle pulse, Out updated this cycle
//   Busy        out  1                   mix in progress; SampleTick not accepted
//   Overrun     out  1                   sticky: SampleTick arrived while Busy (cleared only by Reset)
//   Active      out  NUM_VOICES          voice envelope state != IDLE
// BEHAVIOUR
//   Reset: all phases 0, envelopes 0/IDLE, Out=0, OutValid=0, Busy=0, Overrun=0, Active=0; mid-mix reset aborts, no OutValid.
//   Accepted tick = SampleTick & !Busy, sampled at edge E0. SampleTick & Busy -> ignored, Overrun<=1.
//   At E0, per voice: phase <= phase + PhaseInc (mod 2^PHASE_W); Gate sampled only here; envelope FSM:
//     IDLE    : Gate=1 -> ATTACK (level += ATTACK_STEP this same tick)
//     ATTACK  : level += ATTACK_STEP, saturate at 2^ENV_W-1 -> SUSTAIN; Gate=0 -> RELEASE (no step)
//     SUSTAIN : hold full scale; Gate=0 -> RELEASE
//     RELEASE : level -= RELEASE_STEP, saturate at 0 -> IDLE; Gate=1 -> ATTACK from current level
//   Waveform from p = phase[PHASE_W-1 -: AMP_W]:
//     saw = p ^ (1<<(AMP_W-1)) as signed; square = MSB ? -(2^(AMP_W-1)-1) : +(2^(AMP_W-1)-1);
//     triangle = ((MSB ? ~p : p) << 1) ^ (1<<(AMP_W-1)) as signed; silent = 0. Wave sampled at E0.
//   Mix FSM IDLE -> MIX -> DONE. Busy<=1 at E0. Edges E1..EN: voice k-1 term added to accumulator,
//     term = (wave_signed * {1'b0,level}) >>> ENV_W (arithmetic, product AMP_W+ENV_W+1 bits), using
//     phase/level values updated at E0. Accumulator signed AMP_W+$clog2(NUM_VOICES)+1, cleared at E0.
//   Edge E(N+1): Out <= acc / cnt (signed, truncate toward zero), cnt = voices not IDLE after E0;
//     cnt==0 -> Out<=0. OutValid<=1 for exactly one cycle; Busy<=0. Latency E0->OutValid = NUM_VOICES+1 edges.
//   SampleTick high at E(N+1) is still ignored (Busy was 1); earliest next accept is E(N+2).
//   Active[v] reflects envelope state after E0; Out holds between OutValids.
// TESTING (NUM_VOICES=4, PHASE_W=32, AMP_W=16, ENV_W=4, ATTACK_STEP=15, RELEASE_STEP=5 unless noted)
//   Reset, idle ticks -> Out=0, OutValid pulses, Active=0, every OutValid exactly 5 edges after tick.
//   Gate=0001, PhaseInc0=0x10000000, Wave=00, one tick -> level 15, Out=-26880 (-28672*15>>>4), Active=0001.
//   Gate=0011, both PhaseInc=0x10000000, Wave=01, tick -> both +32767*15>>>4=30719, cnt=2 -> Out=30719.
//   Gate 1->0 after SUSTAIN on voice0 -> levels 10,5,0 on next 3 ticks; Active[0] clears on third; then Out=0.
//   Gate 0->1 while level=5 in RELEASE -> next tick level=15 (saturated), state SUSTAIN.
//   SampleTick at E2 of a mix -> ignored, Overrun=1 sticky, mix result unchanged; Reset at E2 -> no OutValid, all zero.

Source files
------------

// File: rtl/poly_voice_mixer.sv
// Polyphonic NCO tone source: per-voice phase accumulators with linear
// attack/release envelopes, mixed one voice per clock by a shared multiplier
// and normalised by the number of sounding voices.
module poly_voice_mixer #(
  parameter int NUM_VOICES   = 12,
  parameter int PHASE_W      = 32,
  parameter int AMP_W        = 16,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 1,
  parameter int RELEASE_STEP = 1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           SampleTick,
  input  logic [NUM_VOICES*PHASE_W-1:0]  PhaseInc,
  input  logic [NUM_VOICES-1:0]          Gate,
  input  logic [1:0]                     Wave,
  output logic signed [AMP_W-1:0]        Out,
  output logic                           OutValid,
  output logic                           Busy,
  output logic                           Overrun,
  output logic [NUM_VOICES-1:0]          Active
);

  localparam int ACC_W  = AMP_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int PROD_W = AMP_W + ENV_W + 1;

  localparam logic [ENV_W:0]   ENV_FULL = {1'b0, {ENV_W{1'b1}}};
  localparam logic [ENV_W:0]   ATK      = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W:0]   REL      = (ENV_W+1)'(RELEASE_STEP);
  localparam logic [AMP_W-1:0] MSB_BIT  = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [AMP_W-1:0] SQ_POS   = {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic [AMP_W-1:0] SQ_NEG   = {1'b1, {(AMP_W-2){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE} env_t;
  typedef enum logic [1:0] {MIX_IDLE, MIX_RUN, MIX_DONE} mix_t;

  env_t                   env_state  [NUM_VOICES];
  env_t                   env_next   [NUM_VOICES];
  logic [ENV_W-1:0]       level      [NUM_VOICES];
  logic [ENV_W-1:0]       level_next [NUM_VOICES];
  logic [PHASE_W-1:0]     phase      [NUM_VOICES];

  mix_t                   mix_state, mix_next;
  logic [IDX_W-1:0]       idx;
  logic [1:0]             wave_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] divisor;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  logic [AMP_W-1:0]        p;
  logic [AMP_W-1:0]        tri_base;
  logic [AMP_W-1:0]        wav;
  logic signed [PROD_W-1:0] wav_x, lvl_x, prod;

  assign accept = SampleTick & ~Busy;

  // Envelope next-state per voice; only committed on an accepted tick.
  // Entering ATTACK (from IDLE or RELEASE) applies the step immediately, and a
  // step that saturates lands directly in SUSTAIN.
  always_comb begin
    logic [ENV_W:0] up;
    logic           atk_go, rel_go;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      env_next[v]   = env_state[v];
      level_next[v] = level[v];
      up     = {1'b0, level[v]} + ATK;
      atk_go = Gate[v] & (env_state[v] != ENV_SUSTAIN);
      rel_go = ~Gate[v] & ((env_state[v] == ENV_SUSTAIN) || (env_state[v] == ENV_RELEASE));
      if (atk_go) begin
        if (up >= ENV_FULL) begin
          level_next[v] = ENV_FULL[ENV_W-1:0];
          env_next[v]   = ENV_SUSTAIN;
        end else begin
          level_next[v] = up[ENV_W-1:0];
          env_next[v]   = ENV_ATTACK;
        end
      end else if (rel_go) begin
        if ({1'b0, level[v]} <= REL) begin
          level_next[v] = '0;
          env_next[v]   = ENV_IDLE;
        end else begin
          level_next[v] = level[v] - REL[ENV_W-1:0];
          env_next[v]   = ENV_RELEASE;
        end
      end else if (~Gate[v] && env_state[v] == ENV_ATTACK) begin
        env_next[v] = ENV_RELEASE;
      end
    end
  end

  // Per-voice phase and envelope registers, advanced once per accepted tick.
  always_ff @(posedge Clock) begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (Reset) begin
        phase[v]     <= '0;
        level[v]     <= '0;
        env_state[v] <= ENV_IDLE;
      end else if (accept) begin
        phase[v]     <= phase[v] + PhaseInc[v*PHASE_W +: PHASE_W];
        level[v]     <= level_next[v];
        env_state[v] <= env_next[v];
      end
    end
  end

  // Active flags and sounding-voice count.
  always_comb begin
    cnt = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      Active[v] = (env_state[v] != ENV_IDLE);
      cnt       = cnt + CNT_W'(Active[v]);
    end
    divisor = ACC_W'(cnt);
  end

  // Waveform and envelope-scaled term for the voice selected by idx.
  always_comb begin
    p        = phase[idx][PHASE_W-1 -: AMP_W];
    tri_base = p[AMP_W-1] ? ~p : p;
    unique case (wave_q)
      2'b00:   wav = p ^ MSB_BIT;
      2'b01:   wav = p[AMP_W-1] ? SQ_NEG : SQ_POS;
      2'b10:   wav = {tri_base[AMP_W-2:0], 1'b0} ^ MSB_BIT;
      default: wav = '0;
    endcase
    wav_x = PROD_W'($signed(wav));
    lvl_x = PROD_W'({1'b0, level[idx]});
    prod  = wav_x * lvl_x;
  end

  // Mix sequencer state register.
  always_ff @(posedge Clock) begin
    if (Reset) mix_state <= MIX_IDLE;
    else       mix_state <= mix_next;
  end

  // Mix sequencer next state and Busy.
  always_comb begin
    mix_next = mix_state;
    Busy     = (mix_state != MIX_IDLE);
    unique case (mix_state)
      MIX_IDLE: if (SampleTick) mix_next = MIX_RUN;
      MIX_RUN:  if (idx == LAST) mix_next = MIX_DONE;
      MIX_DONE: mix_next = MIX_IDLE;
      default:  mix_next = MIX_IDLE;
    endcase
  end

  // Accumulate one voice per edge, then normalise and publish the sample.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc      <= '0;
      idx      <= '0;
      wave_q   <= '0;
      Out      <= '0;
      OutValid <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      OutValid <= 1'b0;
      if (SampleTick && Busy) Overrun <= 1'b1;
      unique case (mix_state)
        MIX_IDLE: begin
          if (SampleTick) begin
            acc    <= '0;
            idx    <= '0;
            wave_q <= Wave;
          end
        end
        MIX_RUN: begin
          acc <= acc + ACC_W'(prod >>> ENV_W);
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        MIX_DONE: begin
          Out      <= (cnt == '0) ? '0 : AMP_W'(acc / divisor);
          OutValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed testbench for poly_voice_mixer with 4 voices, 4-bit envelopes,
// attack step 15 and release step 5.
module tb_poly_voice_mixer;

  localparam int NV = 4;
  localparam int PW = 32;
  localparam int AW = 16;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic                  SampleTick;
  logic [NV*PW-1:0]      PhaseInc;
  logic [NV-1:0]         Gate;
  logic [1:0]            Wave;
  logic signed [AW-1:0]  Out;
  logic                  OutValid;
  logic                  Busy;
  logic                  Overrun;
  logic [NV-1:0]         Active;

  int compared   = 0;
  int mismatched = 0;

  poly_voice_mixer #(
    .NUM_VOICES  (NV),
    .PHASE_W     (PW),
    .AMP_W       (AW),
    .ENV_W       (4),
    .ATTACK_STEP (15),
    .RELEASE_STEP(5)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SampleTick(SampleTick),
    .PhaseInc  (PhaseInc),
    .Gate      (Gate),
    .Wave      (Wave),
    .Out       (Out),
    .OutValid  (OutValid),
    .Busy      (Busy),
    .Overrun   (Overrun),
    .Active    (Active)
  );

  always #5 Clock = ~Clock;

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1;
    SampleTick = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  // Issue one tick and return the number of edges until OutValid (20 = timeout).
  task automatic do_tick(output int lat);
    @(negedge Clock);
    SampleTick = 1'b1;
    @(posedge Clock);
    #1 SampleTick = 1'b0;
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(posedge Clock);
      #1 lat++;
    end
  endtask

  task automatic test_reset();
    Gate = '0; Wave = 2'b00; PhaseInc = '0;
    apply_reset();
    compared += 5;
    if (Out !== 16'sd0)   begin mismatched++; $display("FAIL reset_out: got %0d expected 0", Out); end
    if (OutValid !== 1'b0) begin mismatched++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
    if (Busy !== 1'b0)    begin mismatched++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", Overrun); end
    if (Active !== 4'b0)  begin mismatched++; $display("FAIL reset_active: got %b expected 0000", Active); end
  endtask

  task automatic test_idle_ticks();
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_tick(lat);
      compared += 3;
      if (lat !== 5)       begin mismatched++; $display("FAIL idle_latency[%0d]: got %0d expected 5", i, lat); end
      if (Out !== 16'sd0)  begin mismatched++; $display("FAIL idle_out[%0d]: got %0d expected 0", i, Out); end
      if (Active !== 4'b0) begin mismatched++; $display("FAIL idle_active[%0d]: got %b expected 0000", i, Active); end
    end
  endtask

  task automatic test_saw();
    int lat;
    apply_reset();
    PhaseInc = '0; PhaseInc[31:0] = 32'h1000_0000;
    Gate = 4'b0001; Wave = 2'b00;
    do_tick(lat);
    compared += 3;
    if (lat !== 5)           begin mismatched++; $display("FAIL saw_latency: got %0d expected 5", lat); end
    if (Out !== -16'sd26880) begin mismatched++; $display("FAIL saw_out: got %0d expected -26880", Out); end
    if (Active !== 4'b0001)  begin mismatched++; $display("FAIL saw_active: got %b expected 0001", Active); end
  endtask

  task automatic test_square();
    int lat;
    apply_reset();
    PhaseInc = '0; PhaseInc[31:0] = 32'h1000_0000; PhaseInc[63:32] = 32'h1000_0000;
    Gate = 4'b0011; Wave = 2'b01;
    do_tick(lat);
    compared += 3;
    if (lat !== 5)          begin mismatched++; $display("FAIL square_latency: got %0d expected 5", lat); end
    if (Out !== 16'sd30719) begin mismatched++; $display("FAIL square_out: got %0d expected 30719", Out); end
    if (Active !== 4'b0011) begin mismatched++; $display("FAIL square_active: got %b expected 0011", Active); end
  endtask

  task automatic test_release();
    logic        gates [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          outs  [6] = '{30719, 30719, 20479, 10239, 0, 0};
    logic [3:0]  acts  [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    int lat;
    apply_reset();
    PhaseInc = '0; Wave = 2'b01;
    for (int i = 0; i < 6; i++) begin
      Gate = {3'b000, gates[i]};
      do_tick(lat);
      compared += 2;
      if (int'(Out) !== outs[i]) begin mismatched++; $display("FAIL release_out[%0d]: got %0d expected %0d", i, Out, outs[i]); end
      if (Active !== acts[i])    begin mismatched++; $display("FAIL release_active[%0d]: got %b expected %b", i, Active, acts[i]); end
    end
  endtask

  task automatic test_retrigger();
    logic gates [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int   outs  [6] = '{30719, 30719, 20479, 10239, 30719, 20479};
    int lat;
    apply_reset();
    PhaseInc = '0; Wave = 2'b01;
    for (int i = 0; i < 6; i++) begin
      Gate = {3'b000, gates[i]};
      do_tick(lat);
      compared += 2;
      if (int'(Out) !== outs[i]) begin mismatched++; $display("FAIL retrigger_out[%0d]: got %0d expected %0d", i, Out, outs[i]); end
      if (Active !== 4'b0001)    begin mismatched++; $display("FAIL retrigger_active[%0d]: got %b expected 0001", i, Active); end
    end
  endtask

  task automatic test_overrun();
    int lat;
    apply_reset();
    PhaseInc = '0; PhaseInc[31:0] = 32'h1000_0000; PhaseInc[63:32] = 32'h1000_0000;
    Gate = 4'b0011; Wave = 2'b00;
    @(negedge Clock);
    SampleTick = 1'b1;
    @(posedge Clock);          // E0
    #1 SampleTick = 1'b0;
    @(posedge Clock);          // E1
    #1 SampleTick = 1'b1;
    @(posedge Clock);          // E2: tick while busy
    #1 SampleTick = 1'b0;
    lat = 2;
    while (!OutValid && lat < 20) begin
      @(posedge Clock);
      #1 lat++;
    end
    compared += 3;
    if (lat !== 5)           begin mismatched++; $display("FAIL overrun_latency: got %0d expected 5", lat); end
    if (Out !== -16'sd26880) begin mismatched++; $display("FAIL overrun_out: got %0d expected -26880", Out); end
    if (Overrun !== 1'b1)    begin mismatched++; $display("FAIL overrun_flag: got %b expected 1", Overrun); end
    do_tick(lat);
    compared += 2;
    if (Out !== -16'sd23040) begin mismatched++; $display("FAIL overrun_next_out: got %0d expected -23040", Out); end
    if (Overrun !== 1'b1)    begin mismatched++; $display("FAIL overrun_sticky: got %b expected 1", Overrun); end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    apply_reset();
    Gate = '0; PhaseInc = '0; Wave = 2'b00;
    @(negedge Clock);
    SampleTick = 1'b1;
    for (int e = 0; e < 40 && second < 0; e++) begin
      @(posedge Clock);
      #1;
      if (OutValid) begin
        if (first < 0) first = e;
        else           second = e;
      end
    end
    SampleTick = 1'b0;
    compared += 3;
    if (first !== 5)           begin mismatched++; $display("FAIL b2b_first: got %0d expected 5", first); end
    if (second - first !== 6)  begin mismatched++; $display("FAIL b2b_gap: got %0d expected 6", second - first); end
    if (Overrun !== 1'b1)      begin mismatched++; $display("FAIL b2b_overrun: got %b expected 1", Overrun); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    apply_reset();
    PhaseInc = '0; PhaseInc[31:0] = 32'h1000_0000; PhaseInc[63:32] = 32'h1000_0000;
    Gate = 4'b0011; Wave = 2'b00;
    @(negedge Clock);
    SampleTick = 1'b1;
    @(posedge Clock);          // E0
    #1 SampleTick = 1'b0;
    @(posedge Clock);          // E1
    #1 Reset = 1'b1;
    @(posedge Clock);          // E2: reset sampled
    #1 Reset = 1'b0;
    Gate = '0;
    compared += 1;
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b expected 0", Busy); end
    for (int e = 0; e < 10; e++) begin
      @(posedge Clock);
      #1;
      if (OutValid) seen++;
    end
    compared += 4;
    if (seen !== 0)       begin mismatched++; $display("FAIL midreset_outvalid: got %0d pulses expected 0", seen); end
    if (Out !== 16'sd0)   begin mismatched++; $display("FAIL midreset_out: got %0d expected 0", Out); end
    if (Active !== 4'b0)  begin mismatched++; $display("FAIL midreset_active: got %b expected 0000", Active); end
    if (Overrun !== 1'b0) begin mismatched++; $display("FAIL midreset_overrun: got %b expected 0", Overrun); end
  endtask

  initial begin
    Reset = 1'b1;
    SampleTick = 1'b0;
    Gate = '0;
    Wave = 2'b00;
    PhaseInc = '0;
    test_reset();
    test_idle_ticks();
    test_saw();
    test_square();
    test_release();
    test_retrigger();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
